writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit.sv | 127 ++++++++++++
 tb/tb_writeback_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Writeback stage: retires instructions into the register bank. ALU and jal
// results are written one cycle after accept. Loads wait for the data memory,
// bounded by a timeout.
module writeback_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rd_in,
  input  logic [4:0]  rt_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] PC_4,
  output logic        mem_rd_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rd_ack,
  input  logic [31:0] mem_rd_data,
  output logic        write_reg_flag,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        mem_timeout
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;

  // Counter value during the last permitted MEM_WAIT cycle.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] counter;
  logic [4:0] load_dest;
  logic       out_of_reset;

  // out_of_reset holds wb_ready low while reset is active and for no longer
  // than the first clock edge after release.
  assign wb_ready = (state == IDLE) && out_of_reset;

  // Main FSM, memory request handshake and register-bank write port.
  // write_reg/write_data are only loaded when a real write happens, so they
  // hold their last value whenever write_reg_flag is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      counter        <= '0;
      load_dest      <= '0;
      out_of_reset   <= 1'b0;
      mem_rd_req     <= 1'b0;
      mem_addr       <= '0;
      write_reg_flag <= 1'b0;
      write_reg      <= '0;
      write_data     <= '0;
      mem_timeout    <= 1'b0;
    end else begin
      out_of_reset   <= 1'b1;
      write_reg_flag <= 1'b0;
      mem_timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (wb_valid && wb_ready) begin
            case (opcode)
              OP_RTYPE: begin
                state <= WRITE;
                if (rd_in != 5'd0) begin
                  write_reg_flag <= 1'b1;
                  write_reg      <= rd_in;
                  write_data     <= alu_result;
                end
              end
              OP_ADDI: begin
                state <= WRITE;
                if (rt_in != 5'd0) begin
                  write_reg_flag <= 1'b1;
                  write_reg      <= rt_in;
                  write_data     <= alu_result;
                end
              end
              OP_JAL: begin
                state          <= WRITE;
                write_reg_flag <= 1'b1;
                write_reg      <= 5'd31;
                write_data     <= PC_4;
              end
              OP_LW: begin
                state      <= MEM_WAIT;
                load_dest  <= rt_in;
                mem_rd_req <= 1'b1;
                mem_addr   <= alu_result;
                counter    <= '0;
              end
              default: ;
            endcase
          end
        end
        MEM_WAIT: begin
          // An ack in the final permitted cycle takes priority over timeout.
          if (mem_rd_ack) begin
            state      <= WRITE;
            mem_rd_req <= 1'b0;
            if (load_dest != 5'd0) begin
              write_reg_flag <= 1'b1;
              write_reg      <= load_dest;
              write_data     <= mem_rd_data;
            end
          end else if (counter == WAIT_LAST) begin
            state       <= IDLE;
            mem_rd_req  <= 1'b0;
            mem_timeout <= 1'b1;
          end else begin
            counter <= counter + 8'd1;
          end
        end
        WRITE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit. Expected register writes are queued
// as stimulus is driven and compared when write_reg_flag fires.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [5:0]  opcode;
  logic [4:0]  rd_in;
  logic [4:0]  rt_in;
  logic [31:0] alu_result;
  logic [31:0] PC_4;
  logic        mem_rd_req;
  logic [31:0] mem_addr;
  logic        mem_rd_ack;
  logic [31:0] mem_rd_data;
  logic        write_reg_flag;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        mem_timeout;

  int checks = 0;
  int errors = 0;
  int timeout_pulses = 0;
  logic [36:0] exp_q[$];

  writeback_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .opcode(opcode), .rd_in(rd_in), .rt_in(rt_in), .alu_result(alu_result),
    .PC_4(PC_4), .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
    .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
    .write_reg_flag(write_reg_flag), .write_reg(write_reg),
    .write_data(write_data), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  // Scoreboard: every register write must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    logic [36:0] e;
    if (!reset && write_reg_flag) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got reg=%0d data=%h expected no write", write_reg, write_data);
      end else begin
        e = exp_q.pop_front();
        if ({write_reg, write_data} !== e) begin
          errors++;
          $display("FAIL wb_scoreboard got reg=%0d data=%h expected reg=%0d data=%h",
                   write_reg, write_data, e[36:32], e[31:0]);
        end
      end
    end
    if (!reset && mem_timeout) timeout_pulses++;
  end

  // Present one instruction at a negedge with wb_ready high; returns at the
  // negedge of the cycle after the accept.
  task automatic issue(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rt,
                       input logic [31:0] alu, input logic [31:0] pc);
    checks++;
    if (wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready got %b expected 1", wb_ready);
    end
    opcode = op; rd_in = rd; rt_in = rt; alu_result = alu; PC_4 = pc;
    wb_valid = 1'b1;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({wb_ready, mem_rd_req, mem_addr, write_reg_flag, write_reg, write_data, mem_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b req=%b addr=%h flag=%b reg=%0d data=%h to=%b expected all 0",
               wb_ready, mem_rd_req, mem_addr, write_reg_flag, write_reg, write_data, mem_timeout);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b expected 1", wb_ready);
    end
  endtask

  task automatic test_rtype;
    exp_q.push_back({5'd8, 32'h0000_0005});
    issue(6'h00, 5'd8, 5'd3, 32'h0000_0005, 32'h0);
    checks++;
    if (write_reg_flag !== 1'b1 || write_reg !== 5'd8 || write_data !== 32'h5 || wb_ready !== 1'b0) begin
      errors++;
      $display("FAIL rtype_write got flag=%b reg=%0d data=%h ready=%b expected 1 8 5 0",
               write_reg_flag, write_reg, write_data, wb_ready);
    end
    @(negedge clk);
    checks++;
    if (write_reg_flag !== 1'b0 || wb_ready !== 1'b1 || write_reg !== 5'd8 || write_data !== 32'h5) begin
      errors++;
      $display("FAIL rtype_idle_hold got flag=%b ready=%b reg=%0d data=%h expected 0 1 8 5",
               write_reg_flag, wb_ready, write_reg, write_data);
    end
  endtask

  task automatic test_jal;
    exp_q.push_back({5'd31, 32'h0040_0010});
    issue(6'h03, 5'd0, 5'd0, 32'h1234_5678, 32'h0040_0010);
    checks++;
    if (write_reg_flag !== 1'b1 || write_reg !== 5'd31 || write_data !== 32'h0040_0010) begin
      errors++;
      $display("FAIL jal_write got flag=%b reg=%0d data=%h expected 1 31 00400010",
               write_reg_flag, write_reg, write_data);
    end
    @(negedge clk);
  endtask

  task automatic test_lw;
    exp_q.push_back({5'd9, 32'hDEAD_BEEF});
    issue(6'h23, 5'd0, 5'd9, 32'h1000_0004, 32'h0);
    checks++;
    if (mem_rd_req !== 1'b1 || mem_addr !== 32'h1000_0004 || wb_ready !== 1'b0) begin
      errors++;
      $display("FAIL lw_request got req=%b addr=%h ready=%b expected 1 10000004 0",
               mem_rd_req, mem_addr, wb_ready);
    end
    repeat (2) @(negedge clk);
    mem_rd_ack = 1'b1; mem_rd_data = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rd_ack = 1'b0; mem_rd_data = '0;
    checks++;
    if (write_reg_flag !== 1'b1 || write_reg !== 5'd9 || write_data !== 32'hDEAD_BEEF || mem_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL lw_write got flag=%b reg=%0d data=%h req=%b expected 1 9 deadbeef 0",
               write_reg_flag, write_reg, write_data, mem_rd_req);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int cnt = 0;
    issue(6'h23, 5'd0, 5'd10, 32'h2000_0000, 32'h0);
    while (mem_rd_req === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 4) begin
      errors++;
      $display("FAIL timeout_req_cycles got %0d expected 4", cnt);
    end
    checks++;
    if (mem_timeout !== 1'b1 || write_reg_flag !== 1'b0 || wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse got to=%b flag=%b ready=%b expected 1 0 1",
               mem_timeout, write_reg_flag, wb_ready);
    end
    @(negedge clk);
    checks++;
    if (mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_one_cycle got %b expected 0", mem_timeout);
    end
  endtask

  task automatic test_ack_at_timeout;
    exp_q.push_back({5'd11, 32'hCAFE_0001});
    issue(6'h23, 5'd0, 5'd11, 32'h3000_0000, 32'h0);
    repeat (3) @(negedge clk);
    mem_rd_ack = 1'b1; mem_rd_data = 32'hCAFE_0001;
    @(negedge clk);
    mem_rd_ack = 1'b0; mem_rd_data = '0;
    checks++;
    if (write_reg_flag !== 1'b1 || mem_timeout !== 1'b0 || write_data !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL ack_at_limit got flag=%b to=%b data=%h expected 1 0 cafe0001",
               write_reg_flag, mem_timeout, write_data);
    end
    @(negedge clk);
  endtask

  task automatic test_no_write;
    issue(6'h08, 5'd7, 5'd0, 32'hFFFF_FFFF, 32'h0);
    checks++;
    if (write_reg_flag !== 1'b0 || wb_ready !== 1'b0 || write_reg !== 5'd11 || write_data !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL addi_r0 got flag=%b ready=%b reg=%0d data=%h expected 0 0 11 cafe0001",
               write_reg_flag, wb_ready, write_reg, write_data);
    end
    @(negedge clk);
    issue(6'h2B, 5'd4, 5'd5, 32'h0000_0100, 32'h0);
    checks++;
    if (write_reg_flag !== 1'b0 || wb_ready !== 1'b1 || mem_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL sw_nowrite got flag=%b ready=%b req=%b expected 0 1 0",
               write_reg_flag, wb_ready, mem_rd_req);
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (wb_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d] got %b expected 1", k, wb_ready);
      end
      exp_q.push_back({5'(k + 1), 32'(100 + k)});
      opcode = 6'h00; rd_in = 5'(k + 1); alu_result = 32'(100 + k);
      wb_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (write_reg_flag !== 1'b1 || wb_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_write[%0d] got flag=%b ready=%b expected 1 0", k, write_reg_flag, wb_ready);
      end
      opcode = 6'h00; rd_in = 5'(k + 2); alu_result = 32'(101 + k);
      if (k == 2) wb_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_wait;
    issue(6'h23, 5'd0, 5'd12, 32'h4000_0000, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({wb_ready, mem_rd_req, mem_addr, write_reg_flag, write_reg, write_data, mem_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_async got ready=%b req=%b addr=%h flag=%b reg=%0d data=%h expected all 0",
               wb_ready, mem_rd_req, mem_addr, write_reg_flag, write_reg, write_data);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_rd_ack = 1'b1; mem_rd_data = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_rd_ack = 1'b0; mem_rd_data = '0;
    checks++;
    if (write_reg_flag !== 1'b0 || mem_rd_req !== 1'b0 || write_reg !== 5'd0 ||
        write_data !== 32'h0 || wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL stray_ack got flag=%b req=%b reg=%0d data=%h ready=%b expected 0 0 0 0 1",
               write_reg_flag, mem_rd_req, write_reg, write_data, wb_ready);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (write_reg_flag !== 1'b0 || mem_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack_late got flag=%b req=%b expected 0 0", write_reg_flag, mem_rd_req);
    end
  endtask

  initial begin
    reset = 1'b1; wb_valid = 1'b0; opcode = '0; rd_in = '0; rt_in = '0;
    alu_result = '0; PC_4 = '0; mem_rd_ack = 1'b0; mem_rd_data = '0;
    @(negedge clk);
    test_reset;
    test_rtype;
    test_jal;
    test_lw;
    test_timeout;
    test_ack_at_timeout;
    test_no_write;
    test_back_to_back;
    test_reset_mid_wait;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_writes got %0d expected 0", exp_q.size());
    end
    checks++;
    if (timeout_pulses != 1) begin
      errors++;
      $display("FAIL timeout_pulse_count got %0d expected 1", timeout_pulses);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired expected completion");
    $fatal(1);
  end

endmodule
